// File: rtl/pvt_mon_pkg.sv
// Shared types and constants for the PVT monitor ring-oscillator scan meter.
package pvt_mon_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, NEXT} osc_meter_state_e;

    localparam int SETTLE_CYC = 4;

    // Select width that stays legal for a single-channel build.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pvt_osc_scan_meter_if.sv
// Control/result bundle of the oscillator scan meter; master drives the scan, slave measures.
interface pvt_osc_scan_meter_if #(
    parameter int NCH = 4,
    parameter int CW  = 12
);
    import pvt_mon_pkg::*;

    localparam int SW = sel_w(NCH);

    logic           start;
    logic           cont;
    logic           stop;
    logic [3:0]     win_log2;
    logic [CW-1:0]  lo_thr;
    logic [CW-1:0]  hi_thr;
    logic [SW-1:0]  rd_sel;
    logic [CW-1:0]  rd_cnt;
    logic [CW-1:0]  min_cnt;
    logic [CW-1:0]  max_cnt;
    logic [NCH-1:0] alarm;
    logic           busy;
    logic           done;
    logic [SW-1:0]  cur_ch;

    modport master (
        output start, cont, stop, win_log2, lo_thr, hi_thr, rd_sel,
        input  rd_cnt, min_cnt, max_cnt, alarm, busy, done, cur_ch
    );

    modport slave (
        input  start, cont, stop, win_log2, lo_thr, hi_thr, rd_sel,
        output rd_cnt, min_cnt, max_cnt, alarm, busy, done, cur_ch
    );

endinterface

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for one divided oscillator plus a one-cycle rising-edge pulse.
module osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic osc,
    output logic edge_pls
);

    logic sync_p0, sync_p1, sync_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= osc;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign edge_pls = sync_p1 & ~sync_p2;

endmodule

// File: rtl/pvt_osc_scan_meter.sv
// Scans NCH oscillator channels, counts edges over a 2**win_log2 window per channel,
// stores counts, flags out-of-band channels and publishes per-scan min/max.
module pvt_osc_scan_meter
    import pvt_mon_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CW       = 12,
    parameter int WLOG_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       osc_in,
    pvt_osc_scan_meter_if.slave  bus
);

    localparam int SW  = sel_w(NCH);
    localparam int WCW = WLOG_MAX + 1;
    localparam int STW = $clog2(SETTLE_CYC);
    localparam logic [CW-1:0] CNT_MAX = '1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    osc_meter_state_e state, state_nxt;

    logic [NCH-1:0] edge_pls;
    logic [STW-1:0] set_cnt;
    logic [WCW-1:0] win_cnt, win_max;
    logic [CW-1:0]  cnt, lo_q, hi_q, run_min, run_max, min_q, max_q;
    logic [CW-1:0]  min_nxt, max_nxt;
    logic [CW-1:0]  res [NCH];
    logic [NCH-1:0] alarm_q;
    logic [SW-1:0]  cur_ch;
    logic [3:0]     wl_clamp;
    logic           done_q, last_ch, settle_last, win_last, edge_cur, meas_alarm;
    logic           busy, cnt_clr, cnt_en, wr_res;

    for (genvar i = 0; i < NCH; i++) begin : g_sync
        osc_edge_sync u_sync (
            .clk      (clk),
            .rst      (rst),
            .osc      (osc_in[i]),
            .edge_pls (edge_pls[i])
        );
    end

    assign wl_clamp    = (bus.win_log2 > 4'(WLOG_MAX)) ? 4'(WLOG_MAX) : bus.win_log2;
    assign last_ch     = (cur_ch == SW'(NCH - 1));
    assign settle_last = (set_cnt == STW'(SETTLE_CYC - 1));
    assign win_last    = (win_cnt == win_max);
    assign edge_cur    = edge_pls[cur_ch];
    assign meas_alarm  = (cnt < lo_q) || (cnt > hi_q);
    // Channel 0 seeds the running extremes for a new scan.
    assign min_nxt     = ((cur_ch == '0) || (cnt < run_min)) ? cnt : run_min;
    assign max_nxt     = ((cur_ch == '0) || (cnt > run_max)) ? cnt : run_max;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !bus.stop) state_nxt = SETTLE;
            SETTLE:  if (bus.stop) state_nxt = IDLE;
                     else if (settle_last) state_nxt = COUNT;
            COUNT:   if (bus.stop) state_nxt = IDLE;
                     else if (win_last) state_nxt = NEXT;
            NEXT:    if (!last_ch) state_nxt = SETTLE;
                     else if (bus.cont && !bus.stop) state_nxt = SETTLE;
                     else state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        wr_res  = 1'b0;
        case (state)
            SETTLE:  begin busy = 1'b1; cnt_clr = 1'b1; end
            COUNT:   begin busy = 1'b1; cnt_en  = 1'b1; end
            NEXT:    begin busy = 1'b1; wr_res  = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            set_cnt <= '0;
            win_cnt <= '0;
            win_max <= '0;
            cnt     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cur_ch  <= '0;
            run_min <= '0;
            run_max <= '0;
            min_q   <= '0;
            max_q   <= '0;
            alarm_q <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) res[i] <= '0;
        end else begin
            done_q  <= 1'b0;
            set_cnt <= cnt_clr ? set_cnt + 1'b1 : '0;
            if (state == IDLE && state_nxt == SETTLE) begin
                win_max <= (WCW'(1) << wl_clamp) - WCW'(1);
                lo_q    <= bus.lo_thr;
                hi_q    <= bus.hi_thr;
                cur_ch  <= '0;
            end
            if (cnt_clr) begin
                cnt     <= '0;
                win_cnt <= '0;
            end
            if (cnt_en) begin
                win_cnt <= win_cnt + 1'b1;
                if (edge_cur) cnt <= sat_inc(cnt);
            end
            if (wr_res) begin
                res[cur_ch]     <= cnt;
                alarm_q[cur_ch] <= meas_alarm;
                run_min         <= min_nxt;
                run_max         <= max_nxt;
                if (last_ch) begin
                    min_q  <= min_nxt;
                    max_q  <= max_nxt;
                    done_q <= 1'b1;
                    cur_ch <= '0;
                end else begin
                    cur_ch <= cur_ch + 1'b1;
                end
            end
        end
    end

    assign bus.rd_cnt  = res[bus.rd_sel];
    assign bus.min_cnt = min_q;
    assign bus.max_cnt = max_q;
    assign bus.alarm   = alarm_q;
    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.cur_ch  = cur_ch;

endmodule
